// File: rtl/drain_edge_monitor.sv
// drain_edge_monitor: synchronises 'drain', counts qualified edges per WINDOW-cycle window, offers each count on out_valid/out_ready.
// Latency: edge_o one cycle wide, 3 cycles after a drain change (5 with the DRAIN_MON_GLITCH_FILTER_EN majority filter).
// Backpressure: an unconsumed result is held stable; a window completing while out_valid&!out_ready is dropped and sets sticky overrun.
module drain_edge_monitor #(
    parameter int WINDOW    = 16,
    parameter int CNT_W     = 8,
    parameter int EDGE_MODE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             drain,
    input  logic             enable,
    input  logic             clr_overrun,
    output logic             edge_o,
    output logic [CNT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             win_end;
    logic             accept;
    logic             drop;

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;
    logic fall;
    logic edge_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= drain;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

`ifdef DRAIN_MON_GLITCH_FILTER_EN
    // flt_lvl only moves once sync2, prev and hist2 (three consecutive samples) agree
    logic hist2;
    logic flt_lvl;
    logic agree;

    assign agree = (sync2 == prev) && (prev == hist2);
    assign rise  = agree &  sync2 & ~flt_lvl;
    assign fall  = agree & ~sync2 &  flt_lvl;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist2   <= 1'b0;
            flt_lvl <= 1'b0;
        end else begin
            hist2 <= prev;
            if (agree) begin
                flt_lvl <= sync2;
            end
        end
    end
`else
    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;
`endif

    always_comb begin
        edge_q = rise | fall;
        if (EDGE_MODE == 0) begin
            edge_q = rise;
        end else if (EDGE_MODE == 1) begin
            edge_q = fall;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            edge_o <= 1'b0;
        end else begin
            edge_o <= edge_q;
        end
    end

    // The window total includes the edge seen on the closing cycle itself
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, edge_q};
    assign cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        cnt_nxt     = cnt;
        win_end     = 1'b0;
        case (state)
            IDLE: begin
                win_cnt_nxt = '0;
                cnt_nxt     = '0;
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt   = IDLE;
                    win_cnt_nxt = '0;
                    cnt_nxt     = '0;
                end else if (win_cnt == WIN_LAST) begin
                    win_end     = 1'b1;
                    win_cnt_nxt = '0;
                    cnt_nxt     = '0;
                end else begin
                    win_cnt_nxt = win_cnt + 1'b1;
                    cnt_nxt     = cnt_sat;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt <= '0;
            cnt     <= '0;
        end else begin
            win_cnt <= win_cnt_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // A held result always wins over a new one; the newer count is the one lost
    assign accept = win_end && (!out_valid || out_ready);
    assign drop   = win_end && out_valid && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= cnt_sat;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    a_hold_stable : assert property (@(posedge clock) disable iff (reset)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_drain_edge_monitor.sv
// Bench for drain_edge_monitor: three instances (both edges, rising only, 4-bit counter) share one stimulus; scoreboard queues hold expected counts.
module tb_drain_edge_monitor;

`ifdef DRAIN_MON_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT     = FILT ? 5 : 3;
    localparam int HP      = FILT ? 4 : 2;
    localparam int TOG_END = FILT ? 64 : 60;
    localparam int TOG_N   = FILT ? 4 : 8;
    localparam int TOG_R   = FILT ? 2 : 4;
    localparam int SAT_M   = FILT ? 0 : 16;
    localparam int SAT_R   = FILT ? 0 : 8;
    localparam int SAT_S   = FILT ? 0 : 15;
    localparam int GL_M    = FILT ? 0 : 2;
    localparam int GL_R    = FILT ? 0 : 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       drain;
    logic       enable;
    logic       clr_overrun;
    logic       out_ready;

    logic       m_edge, m_valid, m_ovr;
    logic [7:0] m_data;
    logic       r_edge, r_valid, r_ovr;
    logic [7:0] r_data;
    logic       s_edge, s_valid, s_ovr;
    logic [3:0] s_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int q_m[$];
    int q_r[$];
    int q_s[$];
    int q_e[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    drain_edge_monitor #(.WINDOW(16), .CNT_W(8), .EDGE_MODE(2)) dut_main (
        .clock(clock), .reset(reset), .drain(drain), .enable(enable),
        .clr_overrun(clr_overrun), .edge_o(m_edge), .out_data(m_data),
        .out_valid(m_valid), .out_ready(out_ready), .overrun(m_ovr));

    drain_edge_monitor #(.WINDOW(16), .CNT_W(8), .EDGE_MODE(0)) dut_rise (
        .clock(clock), .reset(reset), .drain(drain), .enable(enable),
        .clr_overrun(clr_overrun), .edge_o(r_edge), .out_data(r_data),
        .out_valid(r_valid), .out_ready(out_ready), .overrun(r_ovr));

    drain_edge_monitor #(.WINDOW(16), .CNT_W(4), .EDGE_MODE(2)) dut_sat (
        .clock(clock), .reset(reset), .drain(drain), .enable(enable),
        .clr_overrun(clr_overrun), .edge_o(s_edge), .out_data(s_data),
        .out_valid(s_valid), .out_ready(out_ready), .overrun(s_ovr));

    task automatic test_reset();
        reset = 1'b1; drain = 1'b0; enable = 1'b0; clr_overrun = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (m_edge !== 1'b0) begin fails++; $display("FAIL reset_edge got %b expected 0", m_edge); end
        tests++; if (m_data !== 8'd0) begin fails++; $display("FAIL reset_data got %0d expected 0", m_data); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", m_valid); end
        tests++; if (m_ovr !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b expected 0", m_ovr); end
        tests++; if ({r_edge, r_valid, r_ovr, r_data} !== 11'd0) begin fails++; $display("FAIL reset_rise_outputs got %0h expected 0", {r_edge, r_valid, r_ovr, r_data}); end
        tests++; if ({s_edge, s_valid, s_ovr, s_data} !== 7'd0) begin fails++; $display("FAIL reset_sat_outputs got %0h expected 0", {s_edge, s_valid, s_ovr, s_data}); end
        reset = 1'b0;
    endtask

    task automatic test_toggle();
        int exp;
        for (int w = 0; w < 3; w++) begin
            q_m.push_back(TOG_N); q_r.push_back(TOG_R); q_s.push_back(TOG_N);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 72; i++) begin
            @(negedge clock);
            if (m_edge === 1'b1) begin
                tests++;
                if (q_e.size() == 0) begin
                    fails++; $display("FAIL toggle_edge_spurious got edge_o=1 at cycle %0d expected 0", cyc);
                end else begin
                    exp = q_e.pop_front();
                    if (exp !== cyc) begin fails++; $display("FAIL toggle_edge_latency got cycle %0d expected %0d", cyc, exp); end
                end
            end
            if (q_e.size() > 0 && q_e[0] < cyc) begin
                tests++; fails++;
                $display("FAIL toggle_edge_missed got none expected edge_o at cycle %0d", q_e[0]);
                void'(q_e.pop_front());
            end
            if (i == 23 || i == 39 || i == 55) begin
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL toggle_window_timing got valid %b expected 1 at step %0d", m_valid, i); end
            end
            if (m_valid && out_ready) begin
                tests++;
                if (q_m.size() == 0) begin fails++; $display("FAIL toggle_main_extra got %0d expected none", m_data); end
                else begin exp = q_m.pop_front(); if (int'(m_data) !== exp) begin fails++; $display("FAIL toggle_main_data got %0d expected %0d", m_data, exp); end end
            end
            if (r_valid && out_ready) begin
                tests++;
                if (q_r.size() == 0) begin fails++; $display("FAIL toggle_rise_extra got %0d expected none", r_data); end
                else begin exp = q_r.pop_front(); if (int'(r_data) !== exp) begin fails++; $display("FAIL toggle_rise_data got %0d expected %0d", r_data, exp); end end
            end
            if (s_valid && out_ready) begin
                tests++;
                if (q_s.size() == 0) begin fails++; $display("FAIL toggle_sat_extra got %0d expected none", s_data); end
                else begin exp = q_s.pop_front(); if (int'(s_data) !== exp) begin fails++; $display("FAIL toggle_sat_data got %0d expected %0d", s_data, exp); end end
            end
            if (i < TOG_END && i % HP == 0) begin
                drain = ~drain;
                q_e.push_back(cyc + LAT);
            end
            if (i == 6) enable = 1'b1;
            if (i == 66) enable = 1'b0;
        end
        tests++;
        if (q_m.size() + q_r.size() + q_s.size() + q_e.size() != 0) begin
            fails++;
            $display("FAIL toggle_outstanding got %0d unserved expected 0", q_m.size() + q_r.size() + q_s.size() + q_e.size());
        end
        q_m.delete(); q_r.delete(); q_s.delete(); q_e.delete();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 67; i++) begin
            @(negedge clock);
            if (i == 23) begin
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid got %b expected 1", m_valid); end
                tests++; if (m_data !== 8'(TOG_N)) begin fails++; $display("FAIL bp_first_data got %0d expected %0d", m_data, TOG_N); end
                tests++; if (m_ovr !== 1'b0) begin fails++; $display("FAIL bp_no_overrun got %b expected 0", m_ovr); end
            end
            if (i == 39) begin
                tests++; if (m_ovr !== 1'b1) begin fails++; $display("FAIL bp_overrun_set got %b expected 1", m_ovr); end
                tests++; if (m_data !== 8'(TOG_N)) begin fails++; $display("FAIL bp_data_held got %0d expected %0d", m_data, TOG_N); end
                tests++; if (r_ovr !== 1'b1) begin fails++; $display("FAIL bp_rise_overrun got %b expected 1", r_ovr); end
            end
            if (i == 45) begin
                tests++; if (m_ovr !== 1'b0) begin fails++; $display("FAIL bp_overrun_clear got %b expected 0", m_ovr); end
            end
            if (i == 55) begin
                tests++; if (m_ovr !== 1'b1) begin fails++; $display("FAIL bp_set_wins got %b expected 1", m_ovr); end
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_held got %b expected 1", m_valid); end
            end
            if (i == 59) begin
                tests++; if (m_ovr !== 1'b0) begin fails++; $display("FAIL bp_overrun_clear2 got %b expected 0", m_ovr); end
            end
            if (i == 61) begin
                tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_consumed got %b expected 0", m_valid); end
            end
            if (i < TOG_END && i % HP == 0) drain = ~drain;
            clr_overrun = (i == 44 || i == 54 || i == 58);
            if (i == 6) enable = 1'b1;
            if (i == 60) out_ready = 1'b1;
            if (i == 62) enable = 1'b0;
        end
    endtask

    task automatic test_saturate();
        int exp;
        for (int w = 0; w < 2; w++) begin
            q_m.push_back(SAT_M); q_r.push_back(SAT_R); q_s.push_back(SAT_S);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 57; i++) begin
            @(negedge clock);
            if (m_valid && out_ready) begin
                tests++;
                if (q_m.size() == 0) begin fails++; $display("FAIL sat_main_extra got %0d expected none", m_data); end
                else begin exp = q_m.pop_front(); if (int'(m_data) !== exp) begin fails++; $display("FAIL sat_main_data got %0d expected %0d", m_data, exp); end end
            end
            if (r_valid && out_ready) begin
                tests++;
                if (q_r.size() == 0) begin fails++; $display("FAIL sat_rise_extra got %0d expected none", r_data); end
                else begin exp = q_r.pop_front(); if (int'(r_data) !== exp) begin fails++; $display("FAIL sat_rise_data got %0d expected %0d", r_data, exp); end end
            end
            if (s_valid && out_ready) begin
                tests++;
                if (q_s.size() == 0) begin fails++; $display("FAIL sat_cnt4_extra got %0d expected none", s_data); end
                else begin exp = q_s.pop_front(); if (int'(s_data) !== exp) begin fails++; $display("FAIL sat_cnt4_data got %0d expected %0d", s_data, exp); end end
            end
            if (i < 44) drain = ~drain;
            if (i == 6) enable = 1'b1;
            if (i == 50) enable = 1'b0;
        end
        tests++;
        if (q_m.size() + q_r.size() + q_s.size() != 0) begin
            fails++;
            $display("FAIL sat_outstanding got %0d unserved expected 0", q_m.size() + q_r.size() + q_s.size());
        end
        q_m.delete(); q_r.delete(); q_s.delete();
    endtask

    task automatic test_glitch();
        int exp;
        q_m.push_back(GL_M); q_r.push_back(GL_R);
        out_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            if (m_edge === 1'b1) begin
                tests++;
                if (q_e.size() == 0) begin
                    fails++; $display("FAIL glitch_edge_spurious got edge_o=1 at cycle %0d expected 0", cyc);
                end else begin
                    exp = q_e.pop_front();
                    if (exp !== cyc) begin fails++; $display("FAIL glitch_edge_latency got cycle %0d expected %0d", cyc, exp); end
                end
            end
            if (q_e.size() > 0 && q_e[0] < cyc) begin
                tests++; fails++;
                $display("FAIL glitch_edge_missed got none expected edge_o at cycle %0d", q_e[0]);
                void'(q_e.pop_front());
            end
            if (i == 23) begin
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL glitch_window_timing got valid %b expected 1", m_valid); end
            end
            if (m_valid && out_ready) begin
                tests++;
                if (q_m.size() == 0) begin fails++; $display("FAIL glitch_main_extra got %0d expected none", m_data); end
                else begin exp = q_m.pop_front(); if (int'(m_data) !== exp) begin fails++; $display("FAIL glitch_main_data got %0d expected %0d", m_data, exp); end end
            end
            if (r_valid && out_ready) begin
                tests++;
                if (q_r.size() == 0) begin fails++; $display("FAIL glitch_rise_extra got %0d expected none", r_data); end
                else begin exp = q_r.pop_front(); if (int'(r_data) !== exp) begin fails++; $display("FAIL glitch_rise_data got %0d expected %0d", r_data, exp); end end
            end
            if (i == 10 || i == 11) begin
                drain = (i == 10);
                if (!FILT) q_e.push_back(cyc + LAT);
            end
            if (i == 6) enable = 1'b1;
            if (i == 26) enable = 1'b0;
        end
        tests++;
        if (q_m.size() + q_r.size() + q_e.size() != 0) begin
            fails++;
            $display("FAIL glitch_outstanding got %0d unserved expected 0", q_m.size() + q_r.size() + q_e.size());
        end
        q_m.delete(); q_r.delete(); q_e.delete();
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b0;
        for (int i = 0; i < 67; i++) begin
            @(negedge clock);
            if (i == 41) begin
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got %b expected 1", m_valid); end
                tests++; if (m_ovr !== 1'b1) begin fails++; $display("FAIL midrst_pre_overrun got %b expected 1", m_ovr); end
            end
            if (i == 42) begin
                tests++; if (m_edge !== 1'b0) begin fails++; $display("FAIL midrst_edge got %b expected 0", m_edge); end
                tests++; if (m_data !== 8'd0) begin fails++; $display("FAIL midrst_data got %0d expected 0", m_data); end
                tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b expected 0", m_valid); end
                tests++; if (m_ovr !== 1'b0) begin fails++; $display("FAIL midrst_overrun got %b expected 0", m_ovr); end
                tests++; if ({s_edge, s_valid, s_ovr, s_data} !== 7'd0) begin fails++; $display("FAIL midrst_sat_outputs got %0h expected 0", {s_edge, s_valid, s_ovr, s_data}); end
            end
            if (i == 58) begin
                tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midrst_restart_early got valid %b expected 0", m_valid); end
            end
            if (i == 59) begin
                tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL midrst_restart_window got valid %b expected 1", m_valid); end
            end
            if (i < TOG_END && i % HP == 0) drain = ~drain;
            reset = (i == 41);
            if (i == 6) enable = 1'b1;
            if (i == 62) enable = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_backpressure();
        test_saturate();
        test_glitch();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
